alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Control-side driver for the register-file + ALU datapath. Accepts one instruction per
//   valid/ready handshake and sequences a register read, ALU execute and register write-back:
//   it drives a1/a2/opcode, captures alu_result, then pulses we3 with a3/wd3.
//   It sits between an instruction source (bench or fetch unit) and the datapath.
// PARAMETERS
//   DATA_W       32  datapath word width (wd3, alu_result, instr_imm, result)
//   ADDR_W       5   register address width
//   CNT_W        16  width of the completed-instruction counter
//   ZERO_REG_RO  1   1: a write-back to register 0 is suppressed (we3 stays 0)
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   instr_valid  in   1       instruction present on instr_* inputs
//   instr_ready  out  1       sequencer can accept an instruction (high only in IDLE)
//   instr_li     in   1       1: load-immediate (rd <= instr_imm); 0: ALU operation
//   instr_op     in   2       ALU opcode, passed to the ALU unchanged
//   instr_rd     in   ADDR_W  destination register
//   instr_rs1    in   ADDR_W  source register A
//   instr_rs2    in   ADDR_W  source register B
//   instr_imm    in   DATA_W  immediate value for load-immediate
//   a1, a2       out  ADDR_W  register-file read addresses
//   opcode       out  2       ALU opcode
//   alu_result   in   DATA_W  combinational ALU output (from rd1/rd2 of a1/a2)
//   we3          out  1       register-file write enable
//   a3           out  ADDR_W  register-file write address
//   wd3          out  DATA_W  register-file write data
//   done         out  1       one-cycle pulse: instruction retired (cycle of write-back)
//   result       out  DATA_W  value of the last retired instruction, held until the next
//   op_count     out  CNT_W   number of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - FSM states: IDLE, EXEC, WB. Reset state is IDLE.
//   - IDLE: instr_ready=1. On instr_valid&&instr_ready at a clock edge, all instr_* fields
//     are latched. li=0 -> EXEC; li=1 -> WB with the capture register loaded from instr_imm.
//   - EXEC (1 cycle): a1=rs1, a2=rs2, opcode=op from the latched fields. alu_result is
//     captured at the edge ending EXEC, then the FSM enters WB.
//   - WB (1 cycle): a3=rd, wd3=captured value, we3=1 (0 if ZERO_REG_RO && rd==0), and done=1.
//     At the edge ending WB: result <= captured value, op_count += 1 (counts suppressed
//     writes too), FSM -> IDLE.
//   - Latency from the accept edge: ALU op is 2 cycles to the WB cycle; LI is 1 cycle.
//     Throughput is one ALU op per 3 cycles and one LI per 2 cycles.
//   - instr_valid is ignored outside IDLE; the source must hold its fields until accepted.
//   - Back-to-back dependency needs no hazard logic. The write commits at the edge ending WB,
//     before the next instruction can be accepted, so the next read returns the new value.
//   - a1/a2/opcode hold their last values outside EXEC. we3 is 0 in every state except WB.
//   - Reset (asynchronous, any state): FSM -> IDLE, and every output goes to 0 immediately
//     except instr_ready. This covers a1, a2, a3, opcode, wd3, we3, done, result and op_count.
//     instr_ready is 0 while rst is high and 1 in the first cycle after release.
//     Reset in WB aborts the write, so no partial write occurs.
//   - op_count wraps from 2^CNT_W-1 to 0 with no flag.
// TESTING
//   1 Reset: assert rst mid-EXEC -> all outputs 0 at once, and we3 never pulses for that instr.
//   2 LI: li=1, rd=3, imm=32'hDEAD_BEEF -> next cycle we3=1, a3=3, wd3=DEADBEEF, done=1;
//     then result=DEADBEEF and op_count=1.
//   3 ALU: bench ALU model returns a+b for op 2'b00. Preload r1=5, r2=7, then op=00, rd=4,
//     rs1=1, rs2=2 -> EXEC has a1=1, a2=2; WB has a3=4, wd3=12.
//   4 Dependency: r4=12 then issue r5=r4+r4 immediately -> wd3=24, with instr_ready low for
//     exactly 2 cycles after each ALU accept.
//   5 Zero reg: LI rd=0, imm=1 -> done=1, we3 stays 0, op_count increments.
//   6 Wrap: CNT_W=2, retire 5 instructions -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: control-side driver for a register-file + ALU datapath.
// Accepts one instruction per valid/ready handshake and walks it through
// IDLE -> (EXEC) -> WB, driving read addresses, capturing the ALU result and
// pulsing the register-file write enable for one cycle.
module alu_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_RO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_li,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic [1:0]        opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_q;   // latched destination, doubles as the write address
  logic [DATA_W-1:0] cap;    // captured write-back value (imm or ALU result)
  logic              wr_blocked;

  assign wr_blocked = (ZERO_REG_RO != 0) && (rd_q == '0);
  assign a3         = rd_q;
  assign wd3        = cap;

  // State register; reset lands in IDLE from any state, aborting a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-state strobes. instr_ready is gated by rst so it reads
  // low for the whole reset window.
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    we3         = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = ~rst;
        if (instr_valid) state_nx = instr_li ? WB : EXEC;
      end
      EXEC: state_nx = WB;
      WB: begin
        done     = 1'b1;
        we3      = ~wr_blocked;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers. Read addresses are loaded on an ALU accept so they are
  // valid throughout EXEC and then simply hold; LI leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      a1       <= '0;
      a2       <= '0;
      opcode   <= '0;
      cap      <= '0;
      result   <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            rd_q <= instr_rd;
            if (instr_li) begin
              cap <= instr_imm;
            end else begin
              a1     <= instr_rs1;
              a2     <= instr_rs2;
              opcode <= instr_op;
            end
          end
        end
        EXEC: cap <= alu_result;
        WB: begin
          result   <= cap;
          op_count <= op_count + 1'b1;   // suppressed r0 writes still retire
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a behavioural register file
// and ALU, and checks every handshake phase against a reference model that
// tracks architectural register contents and the retire count.
module tb_alu_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid, instr_ready, instr_li;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [DW-1:0] instr_imm;
  logic [AW-1:0] a1, a2, a3;
  logic [1:0]    opcode;
  logic [DW-1:0] alu_result, wd3, result;
  logic          we3, done;
  logic [CW-1:0] op_count;

  alu_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .ZERO_REG_RO(1)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_li(instr_li),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .a1(a1), .a2(a2), .opcode(opcode), .alu_result(alu_result),
    .we3(we3), .a3(a3), .wd3(wd3), .done(done), .result(result),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x & y;
      default: return x ^ y;
    endcase
  endfunction

  // Datapath model: register file written by the DUT, combinational ALU.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (we3) rf[a3] <= wd3;
  always_comb alu_result = alu_f(rf[a1], rf[a2], opcode);

  // Reference model state.
  logic [DW-1:0] ref_rf [32] = '{default: '0};
  int            ref_cnt = 0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from a negedge in IDLE; returns at the negedge after
  // retirement with the DUT back in IDLE.
  task automatic issue(input logic li, input logic [1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm);
    logic [DW-1:0] exp;
    int w;
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    chk("ready_wait", instr_ready, 1);
    exp = li ? imm : alu_f(ref_rf[rs1], ref_rf[rs2], op);
    instr_valid = 1'b1; instr_li = li; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    @(negedge clk);
    instr_valid = 1'b0;
    if (!li) begin
      chk("exec_a1", a1, rs1);
      chk("exec_a2", a2, rs2);
      chk("exec_op", opcode, op);
      chk("exec_rdy", instr_ready, 0);
      chk("exec_we3", we3, 0);
      chk("exec_done", done, 0);
      @(negedge clk);
    end
    chk("wb_we3", we3, (rd != 0));
    chk("wb_a3", a3, rd);
    chk("wb_wd3", wd3, exp);
    chk("wb_done", done, 1);
    chk("wb_rdy", instr_ready, 0);
    if (rd != 0) ref_rf[rd] = exp;
    ref_cnt = (ref_cnt + 1) % (1 << CW);
    @(negedge clk);
    chk("ret_done", done, 0);
    chk("ret_we3", we3, 0);
    chk("ret_result", result, exp);
    chk("ret_count", op_count, ref_cnt);
    chk("ret_rdy", instr_ready, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a1"}, a1, 0);
    chk({tag, "_a2"}, a2, 0);
    chk({tag, "_a3"}, a3, 0);
    chk({tag, "_op"}, opcode, 0);
    chk({tag, "_wd3"}, wd3, 0);
    chk({tag, "_we3"}, we3, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"}, result, 0);
    chk({tag, "_cnt"}, op_count, 0);
    chk({tag, "_rdy"}, instr_ready, 0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_li = 1'b0; instr_op = '0;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    @(negedge clk); @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;
    #1 chk("rel_rdy", instr_ready, 1);
    @(negedge clk);

    // Load immediate
    issue(1'b1, 2'b00, 5'd3, 5'd0, 5'd0, 32'hDEAD_BEEF);
    // ALU add and dependent back-to-back op
    issue(1'b1, 2'b00, 5'd1, 5'd0, 5'd0, 32'd5);
    issue(1'b1, 2'b00, 5'd2, 5'd0, 5'd0, 32'd7);
    issue(1'b0, 2'b00, 5'd4, 5'd1, 5'd2, 32'd0);
    issue(1'b0, 2'b00, 5'd5, 5'd4, 5'd4, 32'd0);
    chk("dep_r4", rf[4], 32'd12);
    chk("dep_r5", rf[5], 32'd24);
    // Zero register is read-only
    issue(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 32'd1);
    chk("zero_r0", rf[0], 32'd0);
    // Counter wrap over five more retirements
    for (int i = 0; i < 5; i++) issue(1'b1, 2'b00, 5'(6 + i), 5'd0, 5'd0, 32'(100 + i));

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    for (int r = 0; r < 32; r++) chk($sformatf("rf_%0d", r), rf[r], ref_rf[r]);

    // Reset mid-EXEC: outputs clear at once and the write never happens.
    instr_valid = 1'b1; instr_li = 1'b0; instr_op = 2'b01; instr_rd = 5'd7;
    instr_rs1 = 5'd3; instr_rs2 = 5'd4; instr_imm = '0;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mid_a1", a1, 5'd3);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    chk("mid_we3", we3, 0);
    rst = 1'b0;
    ref_cnt = 0;
    @(negedge clk);
    chk("mid_rf7", rf[7], ref_rf[7]);
    chk("mid_cnt", op_count, 0);
    chk("mid_rdy", instr_ready, 1);
    issue(1'b0, 2'b10, 5'd8, 5'd3, 5'd5, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
